// File: rtl/cuckoo_hash_engine_if.sv
// Request/response bundle for cuckoo_hash_engine: valid/ready request in,
// one-cycle response pulse out.
interface cuckoo_hash_engine_if #(
  parameter int KEY_W  = 32,
  parameter int IDX_W  = 5,
  parameter int KICK_W = 5
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [KEY_W-1:0]  req_key;
  logic [IDX_W-1:0]  req_idx1;
  logic [IDX_W-1:0]  req_idx2;
  logic              resp_valid;
  logic [2:0]        resp_status;
  logic              resp_table;
  logic [IDX_W-1:0]  resp_index;
  logic [KEY_W-1:0]  resp_key;
  logic [KICK_W-1:0] kick_count;

  modport master (
    output req_valid, req_op, req_key, req_idx1, req_idx2,
    input  req_ready, resp_valid, resp_status, resp_table, resp_index,
           resp_key, kick_count
  );

  modport slave (
    input  req_valid, req_op, req_key, req_idx1, req_idx2,
    output req_ready, resp_valid, resp_status, resp_table, resp_index,
           resp_key, kick_count
  );
endinterface

// File: rtl/cuckoo_hash_engine.sv
// Sequential two-table cuckoo hash: INSERT with bounded displacement, LOOKUP,
// DELETE and CLEAR; each slot stores its key's alternate index.
module cuckoo_hash_engine #(
  parameter int KEY_W     = 32,
  parameter int DEPTH     = 20,
  parameter int IDX_W     = 5,
  parameter int MAX_KICKS = 16,
  parameter int KICK_W    = $clog2(MAX_KICKS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  cuckoo_hash_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_KICK  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_INS = 2'd0;
  localparam logic [1:0] OP_LKP = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  localparam logic [2:0] ST_OK   = 3'd0;
  localparam logic [2:0] ST_DUP  = 3'd1;
  localparam logic [2:0] ST_FAIL = 3'd2;
  localparam logic [2:0] ST_NF   = 3'd3;
  localparam logic [2:0] ST_BAD  = 3'd4;

  localparam logic [IDX_W:0]  DEPTH_X   = (IDX_W + 1)'(DEPTH);
  localparam logic [KICK_W-1:0] LAST_KICK = KICK_W'(MAX_KICKS - 1);

  logic [DEPTH-1:0] r_t1_fill, r_t2_fill;
  logic [KEY_W-1:0] r_t1_key [DEPTH];
  logic [KEY_W-1:0] r_t2_key [DEPTH];
  logic [IDX_W-1:0] r_t1_alt [DEPTH];
  logic [IDX_W-1:0] r_t2_alt [DEPTH];

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [KEY_W-1:0]  r_key;
  logic [IDX_W-1:0]  r_idx1, r_idx2;
  logic [KEY_W-1:0]  r_hkey;
  logic              r_htbl;
  logic [IDX_W-1:0]  r_hidx, r_halt;
  logic [KICK_W-1:0] r_kicks;
  logic [2:0]        r_p_st;
  logic              r_p_tbl;
  logic [IDX_W-1:0]  r_p_idx;
  logic [KEY_W-1:0]  r_p_key;

  logic              r_resp_valid;
  logic [2:0]        r_resp_status;
  logic              r_resp_table;
  logic [IDX_W-1:0]  r_resp_index;
  logic [KEY_W-1:0]  r_resp_key;
  logic [KICK_W-1:0] r_kick_count;

  logic              w_bad;
  logic [IDX_W-1:0]  w_i1, w_i2;
  logic              w_f1, w_f2, w_m1, w_m2;
  logic              w_tf;
  logic [KEY_W-1:0]  w_tk;
  logic [IDX_W-1:0]  w_ta;

  logic              w_we1, w_we2, w_del1, w_del2, w_clr;
  logic [IDX_W-1:0]  w_wi1, w_wi2, w_wa1, w_wa2;
  logic [KEY_W-1:0]  w_wk1, w_wk2;

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_status = r_resp_status;
  assign bus.resp_table  = r_resp_table;
  assign bus.resp_index  = r_resp_index;
  assign bus.resp_key    = r_resp_key;
  assign bus.kick_count  = r_kick_count;

  // Out-of-range indices are steered to slot 0 so reads stay in bounds.
  assign w_bad = ({1'b0, r_idx1} >= DEPTH_X) || ({1'b0, r_idx2} >= DEPTH_X);
  assign w_i1  = w_bad ? '0 : r_idx1;
  assign w_i2  = w_bad ? '0 : r_idx2;
  assign w_f1  = r_t1_fill[w_i1];
  assign w_f2  = r_t2_fill[w_i2];
  assign w_m1  = w_f1 && (r_t1_key[w_i1] == r_key);
  assign w_m2  = w_f2 && (r_t2_key[w_i2] == r_key);

  assign w_tf = r_htbl ? r_t2_fill[r_hidx] : r_t1_fill[r_hidx];
  assign w_tk = r_htbl ? r_t2_key[r_hidx]  : r_t1_key[r_hidx];
  assign w_ta = r_htbl ? r_t2_alt[r_hidx]  : r_t1_alt[r_hidx];

  always_comb begin
    w_we1  = 1'b0;
    w_we2  = 1'b0;
    w_del1 = 1'b0;
    w_del2 = 1'b0;
    w_clr  = 1'b0;
    w_wi1  = w_i1;
    w_wi2  = w_i2;
    w_wk1  = r_key;
    w_wk2  = r_key;
    w_wa1  = r_idx2;
    w_wa2  = r_idx1;
    case (r_state)
      S_CHECK: begin
        if (!w_bad) begin
          case (r_op)
            OP_INS: if (!w_m1 && !w_m2) begin
              // Empty t1 slot or both full (evict t1) both write t1[idx1].
              if (!w_f1 || w_f2) w_we1 = 1'b1;
              else               w_we2 = 1'b1;
            end
            OP_DEL: begin
              if (w_m1)      w_del1 = 1'b1;
              else if (w_m2) w_del2 = 1'b1;
            end
            OP_CLR:  w_clr = 1'b1;
            default: ;
          endcase
        end
      end
      S_KICK: begin
        w_wi1 = r_hidx;
        w_wi2 = r_hidx;
        w_wk1 = r_hkey;
        w_wk2 = r_hkey;
        w_wa1 = r_halt;
        w_wa2 = r_halt;
        if (r_htbl) w_we2 = 1'b1;
        else        w_we1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1_fill <= '0;
      r_t2_fill <= '0;
    end else if (w_clr) begin
      r_t1_fill <= '0;
      r_t2_fill <= '0;
    end else begin
      if (w_we1)  r_t1_fill[w_wi1] <= 1'b1;
      if (w_del1) r_t1_fill[w_wi1] <= 1'b0;
      if (w_we2)  r_t2_fill[w_wi2] <= 1'b1;
      if (w_del2) r_t2_fill[w_wi2] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we1) begin
      r_t1_key[w_wi1] <= w_wk1;
      r_t1_alt[w_wi1] <= w_wa1;
    end
    if (w_we2) begin
      r_t2_key[w_wi2] <= w_wk2;
      r_t2_alt[w_wi2] <= w_wa2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_INS;
      r_key         <= '0;
      r_idx1        <= '0;
      r_idx2        <= '0;
      r_hkey        <= '0;
      r_htbl        <= 1'b0;
      r_hidx        <= '0;
      r_halt        <= '0;
      r_kicks       <= '0;
      r_p_st        <= ST_OK;
      r_p_tbl       <= 1'b0;
      r_p_idx       <= '0;
      r_p_key       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
      r_resp_table  <= 1'b0;
      r_resp_index  <= '0;
      r_resp_key    <= '0;
      r_kick_count  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_op    <= bus.req_op;
          r_key   <= bus.req_key;
          r_idx1  <= bus.req_idx1;
          r_idx2  <= bus.req_idx2;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_p_st  <= ST_OK;
          r_p_tbl <= 1'b0;
          r_p_idx <= '0;
          r_p_key <= r_key;
          r_kicks <= '0;
          r_state <= S_RESP;
          if (w_bad) begin
            r_p_st <= ST_BAD;
          end else if (r_op != OP_CLR) begin
            if (w_m1) begin
              r_p_st  <= (r_op == OP_INS) ? ST_DUP : ST_OK;
              r_p_idx <= r_idx1;
            end else if (w_m2) begin
              r_p_st  <= (r_op == OP_INS) ? ST_DUP : ST_OK;
              r_p_tbl <= 1'b1;
              r_p_idx <= r_idx2;
            end else if (r_op != OP_INS) begin
              r_p_st <= ST_NF;
            end else if (!w_f1) begin
              r_p_idx <= r_idx1;
            end else if (!w_f2) begin
              r_p_tbl <= 1'b1;
              r_p_idx <= r_idx2;
            end else begin
              // New key took t1[idx1]; its former occupant heads to table 2.
              r_p_idx <= r_idx1;
              r_kicks <= KICK_W'(1);
              r_hkey  <= r_t1_key[w_i1];
              r_htbl  <= 1'b1;
              r_hidx  <= r_t1_alt[w_i1];
              r_halt  <= r_idx1;
              if (MAX_KICKS == 1) begin
                r_p_st  <= ST_FAIL;
                r_p_key <= r_t1_key[w_i1];
              end else begin
                r_state <= S_KICK;
              end
            end
          end
        end
        S_KICK: begin
          if (!w_tf) begin
            r_state <= S_RESP;
          end else begin
            r_kicks <= r_kicks + 1'b1;
            r_hkey  <= w_tk;
            r_htbl  <= ~r_htbl;
            r_hidx  <= w_ta;
            r_halt  <= r_hidx;
            if (r_kicks == LAST_KICK) begin
              r_p_st  <= ST_FAIL;
              r_p_key <= w_tk;
              r_state <= S_RESP;
            end
          end
        end
        default: begin
          r_resp_valid  <= 1'b1;
          r_resp_status <= r_p_st;
          r_resp_table  <= r_p_tbl;
          r_resp_index  <= r_p_idx;
          r_resp_key    <= r_p_key;
          if (r_op == OP_INS) r_kick_count <= r_kicks;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cuckoo_hash_engine.sv
// Directed bench for cuckoo_hash_engine (DEPTH 20, MAX_KICKS 4) with
// hand-computed responses, latencies and table contents via lookups.
module tb_cuckoo_hash_engine;
  localparam int KEY_W = 32;
  localparam int IDX_W = 5;
  localparam int MAXK  = 4;
  localparam int KW    = $clog2(MAXK + 1);

  localparam logic [1:0] INS = 2'd0, LKP = 2'd1, DEL = 2'd2, CLR = 2'd3;
  localparam logic [2:0] OK = 3'd0, DUP = 3'd1, FL = 3'd2, NF = 3'd3, BAD = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cuckoo_hash_engine_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .KICK_W(KW)) bus ();

  cuckoo_hash_engine #(
    .KEY_W(KEY_W), .DEPTH(20), .IDX_W(IDX_W), .MAX_KICKS(MAXK), .KICK_W(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] key,
                     input logic [4:0] i1, input logic [4:0] i2,
                     input logic [2:0] est, input bit chk_loc,
                     input logic etbl, input logic [4:0] eidx,
                     input logic [31:0] ekey, input int elat,
                     input logic [KW-1:0] ekc);
    string tag;
    int    lat;
    tag = $sformatf("op%0d_k%0d_%0d_%0d", op, key, i1, i2);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_idx1  = i1;
    bus.req_idx2  = i2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_key   = 32'hdead_beef;
    chk({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.resp_valid) break;
    end
    if (!bus.resp_valid) begin
      chk({tag, "_timeout"}, 64'(bus.resp_valid), 64'd1);
      return;
    end
    chk({tag, "_lat"},    64'(lat), 64'(elat));
    chk({tag, "_status"}, 64'(bus.resp_status), 64'(est));
    chk({tag, "_key"},    64'(bus.resp_key), 64'(ekey));
    chk({tag, "_kicks"},  64'(bus.kick_count), 64'(ekc));
    if (chk_loc) begin
      chk({tag, "_table"}, 64'(bus.resp_table), 64'(etbl));
      chk({tag, "_index"}, 64'(bus.resp_index), 64'(eidx));
    end
    @(posedge clk);
    #1;
    chk({tag, "_pulse"},  64'(bus.resp_valid), 64'd0);
    chk({tag, "_hold"},   64'(bus.resp_status), 64'(est));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = INS;
    bus.req_key   = '0;
    bus.req_idx1  = '0;
    bus.req_idx2  = '0;
    do_reset();
    chk("rst_ready",  64'(bus.req_ready), 64'd1);
    chk("rst_valid",  64'(bus.resp_valid), 64'd0);
    chk("rst_status", 64'(bus.resp_status), 64'd0);
    chk("rst_table",  64'(bus.resp_table), 64'd0);
    chk("rst_index",  64'(bus.resp_index), 64'd0);
    chk("rst_key",    64'(bus.resp_key), 64'd0);
    chk("rst_kicks",  64'(bus.kick_count), 64'd0);

    // Basic placement.
    req(INS, 70, 0, 10, OK, 1, 0, 0, 70, 2, 0);
    req(INS, 82, 8, 2, OK, 1, 0, 8, 82, 2, 0);
    req(INS, 11, 11, 19, OK, 1, 0, 11, 11, 2, 0);
    req(INS, 91, 11, 11, OK, 1, 1, 11, 91, 2, 0);
    req(INS, 13, 17, 5, OK, 1, 0, 17, 13, 2, 0);
    req(LKP, 91, 11, 11, OK, 1, 1, 11, 91, 2, 0);
    req(LKP, 12, 3, 4, NF, 0, 0, 0, 12, 2, 0);
    req(INS, 82, 8, 2, DUP, 1, 0, 8, 82, 2, 0);

    // Single displacement.
    do_reset();
    req(INS, 70, 0, 10, OK, 1, 0, 0, 70, 2, 0);
    req(INS, 44, 0, 4, OK, 1, 1, 4, 44, 2, 0);
    req(INS, 60, 0, 4, OK, 0, 0, 0, 60, 3, 1);
    req(LKP, 60, 0, 4, OK, 1, 0, 0, 60, 2, 1);
    req(LKP, 70, 0, 10, OK, 1, 1, 10, 70, 2, 1);
    req(LKP, 44, 0, 4, OK, 1, 1, 4, 44, 2, 1);

    // Displacement limit: 70 is orphaned after four evictions.
    do_reset();
    req(INS, 70, 0, 10, OK, 1, 0, 0, 70, 2, 0);
    req(INS, 30, 0, 10, OK, 1, 1, 10, 30, 2, 0);
    req(INS, 50, 0, 10, FL, 0, 0, 0, 70, 5, 4);
    req(LKP, 30, 0, 10, OK, 1, 0, 0, 30, 2, 4);
    req(LKP, 50, 0, 10, OK, 1, 1, 10, 50, 2, 4);
    req(LKP, 70, 0, 10, NF, 0, 0, 0, 70, 2, 4);

    // Bad indices leave the tables alone.
    req(INS, 5, 20, 1, BAD, 0, 0, 0, 5, 2, 0);
    req(INS, 5, 1, 20, BAD, 0, 0, 0, 5, 2, 0);
    req(LKP, 5, 0, 1, NF, 0, 0, 0, 5, 2, 0);
    req(LKP, 5, 1, 0, NF, 0, 0, 0, 5, 2, 0);
    req(LKP, 30, 0, 10, OK, 1, 0, 0, 30, 2, 0);

    // Delete and clear.
    req(DEL, 30, 0, 10, OK, 1, 0, 0, 30, 2, 0);
    req(LKP, 30, 0, 10, NF, 0, 0, 0, 30, 2, 0);
    req(DEL, 30, 0, 10, NF, 0, 0, 0, 30, 2, 0);
    req(DEL, 50, 0, 10, OK, 1, 1, 10, 50, 2, 0);
    req(INS, 13, 17, 5, OK, 1, 0, 17, 13, 2, 0);
    req(CLR, 0, 0, 0, OK, 1, 0, 0, 0, 2, 0);
    req(LKP, 13, 17, 5, NF, 0, 0, 0, 13, 2, 0);
    req(INS, 50, 0, 10, OK, 1, 0, 0, 50, 2, 0);

    // Reset while the engine is in a KICK cycle.
    req(INS, 30, 0, 10, OK, 1, 1, 10, 30, 2, 0);
    req(INS, 77, 3, 3, OK, 1, 0, 3, 77, 2, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = INS;
    bus.req_key   = 99;
    bus.req_idx1  = 0;
    bus.req_idx2  = 10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready",  64'(bus.req_ready), 64'd1);
    chk("midrst_valid",  64'(bus.resp_valid), 64'd0);
    chk("midrst_status", 64'(bus.resp_status), 64'd0);
    chk("midrst_index",  64'(bus.resp_index), 64'd0);
    chk("midrst_key",    64'(bus.resp_key), 64'd0);
    chk("midrst_kicks",  64'(bus.kick_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_ready", 64'(bus.req_ready), 64'd1);
    chk("postrst_valid", 64'(bus.resp_valid), 64'd0);
    req(LKP, 50, 0, 10, NF, 0, 0, 0, 50, 2, 0);
    req(LKP, 30, 0, 10, NF, 0, 0, 0, 30, 2, 0);
    req(LKP, 77, 3, 3, NF, 0, 0, 0, 77, 2, 0);
    req(LKP, 99, 0, 10, NF, 0, 0, 0, 99, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
